// File: rtl/baser_257b_stream_checker.sv
// ---------------------------------------------------------------------------
// baser_257b_stream_checker
//
// Monitoring tap for the 257b transcoded BASE-R TX stream. It classifies every
// valid block as all-data (header=1) or control (header=0). All-data payload
// bytes are compared against a fixed character. A control block whose mask is
// all ones is illegal. Saturating statistics are kept, and a lock FSM tracks
// runs of good and bad blocks. The tap only observes and never drives the
// datapath.
//
// Ports
//   clk             clock
//   i_rst           synchronous active-high reset (priority over everything)
//   i_valid         i_tx_coded carries a block this cycle
//   i_tx_coded      transcoded block, bit 0 = header
//   i_clear         synchronous clear of the five statistics counters
//   o_block_count   valid blocks received
//   o_data_count    header=1 blocks
//   o_ctrl_count    header=0 blocks
//   o_pattern_err   all-data blocks with at least one byte != pattern
//   o_mask_err      header=0 blocks with an all-ones mask
//   o_err_pulse     one-cycle pulse: the block registered last cycle was bad
//   o_lock          1 = LOCKED
// All outputs are registered and reflect the block sampled on the previous edge.
// ---------------------------------------------------------------------------
module baser_257b_stream_checker #(
    parameter int         DATA_WIDTH        = 64,
    parameter int         NUM_SUBBLK        = 4,
    parameter int         TC_WIDTH          = DATA_WIDTH*NUM_SUBBLK+1,
    parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
    parameter int         CNT_WIDTH         = 32,
    parameter int         LOCK_GOOD         = 16,
    parameter int         UNLOCK_BAD        = 4
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [TC_WIDTH-1:0]  i_tx_coded,
    input  logic                 i_clear,
    output logic [CNT_WIDTH-1:0] o_block_count,
    output logic [CNT_WIDTH-1:0] o_data_count,
    output logic [CNT_WIDTH-1:0] o_ctrl_count,
    output logic [CNT_WIDTH-1:0] o_pattern_err,
    output logic [CNT_WIDTH-1:0] o_mask_err,
    output logic                 o_err_pulse,
    output logic                 o_lock
);

    localparam int NUM_BYTES = (TC_WIDTH-1)/8;
    localparam int GW        = (LOCK_GOOD  > 1) ? $clog2(LOCK_GOOD)  : 1;
    localparam int BW        = (UNLOCK_BAD > 1) ? $clog2(UNLOCK_BAD) : 1;

    // Run counters only need to reach threshold-1: the edge that would reach
    // the threshold changes state and zeroes them instead.
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD-1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_BAD-1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic w_hdr;
    logic w_pattern_bad;
    logic w_mask_bad;
    logic w_bad;

    // ---- stage p0: combinational classification of the incoming block ----
    always_comb begin
        w_hdr         = i_tx_coded[0];
        w_pattern_bad = 1'b0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i_tx_coded[8*i+1 +: 8] != DATA_CHAR_PATTERN)
                w_pattern_bad = 1'b1;
        end
        w_mask_bad = &i_tx_coded[NUM_SUBBLK:1];
        w_bad      = w_hdr ? w_pattern_bad : w_mask_bad;
    end

    logic [CNT_WIDTH-1:0] r_block_cnt_p1;
    logic [CNT_WIDTH-1:0] r_data_cnt_p1;
    logic [CNT_WIDTH-1:0] r_ctrl_cnt_p1;
    logic [CNT_WIDTH-1:0] r_pat_err_p1;
    logic [CNT_WIDTH-1:0] r_mask_err_p1;
    logic                 r_err_pulse_p1;

    // ---- stage p1: statistics counters and error pulse ----
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_block_cnt_p1 <= '0;
            r_data_cnt_p1  <= '0;
            r_ctrl_cnt_p1  <= '0;
            r_pat_err_p1   <= '0;
            r_mask_err_p1  <= '0;
            r_err_pulse_p1 <= 1'b0;
        end else begin
            r_err_pulse_p1 <= i_valid & w_bad;
            if (i_clear) begin
                // A block sampled together with clear is deliberately not counted.
                r_block_cnt_p1 <= '0;
                r_data_cnt_p1  <= '0;
                r_ctrl_cnt_p1  <= '0;
                r_pat_err_p1   <= '0;
                r_mask_err_p1  <= '0;
            end else if (i_valid) begin
                r_block_cnt_p1 <= sat_inc(r_block_cnt_p1);
                if (w_hdr) begin
                    r_data_cnt_p1 <= sat_inc(r_data_cnt_p1);
                    if (w_pattern_bad)
                        r_pat_err_p1 <= sat_inc(r_pat_err_p1);
                end else begin
                    r_ctrl_cnt_p1 <= sat_inc(r_ctrl_cnt_p1);
                    if (w_mask_bad)
                        r_mask_err_p1 <= sat_inc(r_mask_err_p1);
                end
            end
        end
    end

    lock_state_t     r_state_p1;
    logic [GW-1:0]   r_good_run_p1;
    logic [BW-1:0]   r_bad_run_p1;
    logic            r_lock_p1;

    // ---- stage p1: lock FSM (unaffected by i_clear, idle cycles hold state) ----
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state_p1    <= ST_UNLOCKED;
            r_good_run_p1 <= '0;
            r_bad_run_p1  <= '0;
            r_lock_p1     <= 1'b0;
        end else if (i_valid) begin
            case (r_state_p1)
                ST_UNLOCKED: begin
                    if (w_bad) begin
                        r_good_run_p1 <= '0;
                    end else if (r_good_run_p1 == GOOD_LAST) begin
                        r_state_p1    <= ST_LOCKED;
                        r_lock_p1     <= 1'b1;
                        r_good_run_p1 <= '0;
                        r_bad_run_p1  <= '0;
                    end else begin
                        r_good_run_p1 <= r_good_run_p1 + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_bad) begin
                        r_bad_run_p1 <= '0;
                    end else if (r_bad_run_p1 == BAD_LAST) begin
                        r_state_p1    <= ST_UNLOCKED;
                        r_lock_p1     <= 1'b0;
                        r_good_run_p1 <= '0;
                        r_bad_run_p1  <= '0;
                    end else begin
                        r_bad_run_p1 <= r_bad_run_p1 + 1'b1;
                    end
                end
                default: begin
                    r_state_p1    <= ST_UNLOCKED;
                    r_lock_p1     <= 1'b0;
                    r_good_run_p1 <= '0;
                    r_bad_run_p1  <= '0;
                end
            endcase
        end
    end

    assign o_block_count = r_block_cnt_p1;
    assign o_data_count  = r_data_cnt_p1;
    assign o_ctrl_count  = r_ctrl_cnt_p1;
    assign o_pattern_err = r_pat_err_p1;
    assign o_mask_err    = r_mask_err_p1;
    assign o_err_pulse   = r_err_pulse_p1;
    assign o_lock        = r_lock_p1;

endmodule

// File: tb/tb_baser_257b_stream_checker.sv
module tb_baser_257b_stream_checker;

    localparam int TCW = 257;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic           clear;
    logic [TCW-1:0] blk;

    logic [31:0] d_blk, d_data, d_ctrl, d_pat, d_mask;
    logic        d_pulse, d_lock;
    logic [3:0]  s_blk, s_data, s_ctrl, s_pat, s_mask;
    logic        s_pulse, s_lock;

    always #5 clk = ~clk;

    baser_257b_stream_checker dut (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_tx_coded(blk), .i_clear(clear),
        .o_block_count(d_blk), .o_data_count(d_data), .o_ctrl_count(d_ctrl),
        .o_pattern_err(d_pat), .o_mask_err(d_mask), .o_err_pulse(d_pulse), .o_lock(d_lock)
    );

    baser_257b_stream_checker #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_tx_coded(blk), .i_clear(clear),
        .o_block_count(s_blk), .o_data_count(s_data), .o_ctrl_count(s_ctrl),
        .o_pattern_err(s_pat), .o_mask_err(s_mask), .o_err_pulse(s_pulse), .o_lock(s_lock)
    );

    typedef struct {
        int blk, data, ctrl, pat, mask;
        bit pulse, lock;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    // reference state: counts kept unbounded, saturation applied at compare
    int m_blk, m_data, m_ctrl, m_pat, m_mask, m_good, m_bad;
    bit m_pulse, m_lock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic [TCW-1:0] mk_data(input int bad_idx, input logic [7:0] bad_val);
        logic [TCW-1:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b[8*i+1 +: 8] = 8'hAA;
        if (bad_idx >= 0) b[8*bad_idx+1 +: 8] = bad_val;
        b[0] = 1'b1;
        return b;
    endfunction

    function automatic logic [TCW-1:0] mk_ctrl(input logic [3:0] mask);
        logic [TCW-1:0] b;
        for (int i = 0; i < TCW; i++) b[i] = 1'($urandom_range(0, 1));
        b[4:1] = mask;
        b[0]   = 1'b0;
        return b;
    endfunction

    function automatic bit is_bad(input logic [TCW-1:0] b);
        if (b[0]) begin
            for (int i = 0; i < 32; i++)
                if (b[8*i+1 +: 8] != 8'hAA) return 1'b1;
            return 1'b0;
        end
        return (b[4:1] == 4'b1111);
    endfunction

    task automatic model_step(input bit v, input logic [TCW-1:0] b, input bit c, input bit r);
        bit bad;
        exp_t e;
        bad = is_bad(b);
        if (r) begin
            m_blk = 0; m_data = 0; m_ctrl = 0; m_pat = 0; m_mask = 0;
            m_good = 0; m_bad = 0; m_pulse = 0; m_lock = 0;
        end else begin
            m_pulse = v && bad;
            if (c) begin
                m_blk = 0; m_data = 0; m_ctrl = 0; m_pat = 0; m_mask = 0;
            end else if (v) begin
                m_blk++;
                if (b[0]) begin m_data++; if (bad) m_pat++; end
                else begin m_ctrl++; if (bad) m_mask++; end
            end
            if (v) begin
                if (!m_lock) begin
                    if (bad) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good >= 16) begin m_lock = 1; m_good = 0; m_bad = 0; end
                    end
                end else begin
                    if (!bad) m_bad = 0;
                    else begin
                        m_bad++;
                        if (m_bad >= 4) begin m_lock = 0; m_good = 0; m_bad = 0; end
                    end
                end
            end
        end
        e.blk = m_blk; e.data = m_data; e.ctrl = m_ctrl; e.pat = m_pat; e.mask = m_mask;
        e.pulse = m_pulse; e.lock = m_lock;
        sb.push_back(e);
    endtask

    // Drive one cycle, push the expectation, then compare both DUTs after the edge.
    task automatic cyc(input bit v, input logic [TCW-1:0] b, input bit c, input bit r);
        exp_t e;
        valid = v; blk = b; clear = c; rst = r;
        model_step(v, b, c, r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("blk",     d_blk,   e.blk);
            check_eq("data",    d_data,  e.data);
            check_eq("ctrl",    d_ctrl,  e.ctrl);
            check_eq("pat",     d_pat,   e.pat);
            check_eq("mask",    d_mask,  e.mask);
            check_eq("pulse",   d_pulse, e.pulse);
            check_eq("lock",    d_lock,  e.lock);
            check_eq("s_blk",   s_blk,   sat15(e.blk));
            check_eq("s_data",  s_data,  sat15(e.data));
            check_eq("s_ctrl",  s_ctrl,  sat15(e.ctrl));
            check_eq("s_pat",   s_pat,   sat15(e.pat));
            check_eq("s_mask",  s_mask,  sat15(e.mask));
            check_eq("s_pulse", s_pulse, e.pulse);
            check_eq("s_lock",  s_lock,  e.lock);
        end
        valid = 1'b0; clear = 1'b0; rst = 1'b0;
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, mk_data(-1, 8'h00), 1'b0, 1'b0);
    endtask

    initial begin
        logic [TCW-1:0] zb;
        zb = '0;
        valid = 1'b0; clear = 1'b0; rst = 1'b1; blk = '0;

        // reset, including a valid garbage block that reset must discard
        cyc(1'b1, mk_data(3, 8'h00), 1'b1, 1'b1);
        cyc(1'b0, zb, 1'b0, 1'b1);
        check_eq("rst_lock", d_lock, 0);
        check_eq("rst_blk", d_blk, 0);

        // 1: 16 good data blocks with idle gaps that must not break the run
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_eq("t1_prelock", d_lock, 0);
            cyc(1'b1, mk_data(-1, 8'h00), 1'b0, 1'b0);
            if (i % 5 == 2) cyc(1'b0, mk_data(0, 8'h12), 1'b0, 1'b0);
        end
        check_eq("t1_lock", d_lock, 1);
        check_eq("t1_blk", d_blk, 16);
        check_eq("t1_data", d_data, 16);
        check_eq("t1_pat", d_pat, 0);

        // 2: 3 bad, 1 good, 4 bad
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, mk_data(0, 8'hAB), 1'b0, 1'b0);
            check_eq("t2_pulse", d_pulse, 1);
        end
        check_eq("t2_lock3", d_lock, 1);
        good(1);
        check_eq("t2_nopulse", d_pulse, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check_eq("t2_lock_before4", d_lock, 1);
            cyc(1'b1, mk_data(i * 7, 8'h55), 1'b0, 1'b0);
            check_eq("t2_pulse2", d_pulse, 1);
        end
        check_eq("t2_unlock", d_lock, 0);
        check_eq("t2_pat", d_pat, 7);

        // 3: illegal then legal control mask
        cyc(1'b1, mk_ctrl(4'b1111), 1'b0, 1'b0);
        check_eq("t3_pulse_f", d_pulse, 1);
        cyc(1'b1, mk_ctrl(4'b0110), 1'b0, 1'b0);
        check_eq("t3_pulse_6", d_pulse, 0);
        check_eq("t3_ctrl", d_ctrl, 2);
        check_eq("t3_mask", d_mask, 1);

        // 5: relock, then clear with a valid block
        good(16);
        check_eq("t5_lock", d_lock, 1);
        cyc(1'b1, mk_data(-1, 8'h00), 1'b1, 1'b0);
        check_eq("t5_blk0", d_blk, 0);
        check_eq("t5_data0", d_data, 0);
        check_eq("t5_lock_kept", d_lock, 1);

        // 6: reset mid-run restarts the good run
        cyc(1'b0, zb, 1'b0, 1'b1);
        good(10);
        cyc(1'b0, zb, 1'b0, 1'b1);
        good(15);
        check_eq("t6_lock", d_lock, 0);
        check_eq("t6_blk", d_blk, 15);
        check_eq("t6_s_blk", s_blk, 15);

        // 4: narrow counters hold at max
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, (i % 3 == 0) ? mk_ctrl(4'b1111) : mk_data(i, 8'h00), 1'b0, 1'b0);
        end
        check_eq("t4_s_blk_sat", s_blk, 15);
        check_eq("t4_d_blk", d_blk, 35);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            bit v, c;
            int k;
            logic [TCW-1:0] b;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 31) == 0);
            k = $urandom_range(0, 5);
            if (k < 3)      b = mk_data(-1, 8'h00);
            else if (k == 3) b = mk_data($urandom_range(0, 31), 8'hAA ^ 8'($urandom_range(1, 255)));
            else            b = mk_ctrl(4'($urandom_range(0, 15)));
            cyc(v, b, c, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
